// File: rtl/ahb_slave_ctrl_pipe.sv
// AHB-Lite slave control for the USB endpoint window: address/data phase pipeline,
// buffer/register strobes, busy wait states with timeout, and the two-cycle ERROR response.
module ahb_slave_ctrl_pipe #(
   parameter int ADDR_W     = 7,
   parameter int BUF_BYTES  = 64,
   parameter int REG_BASE   = 64,
   parameter int TXSIZE_OFS = 8,
   parameter int WAIT_MAX   = 15
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic [1:0]        hsize,
   input  logic              hwrite,
   input  logic              bufBusy,
   output logic [2:0]        state,
   output logic              storeTxData,
   output logic              getRxData,
   output logic              regWrite,
   output logic              regRead,
   output logic [ADDR_W-1:0] dataAddr,
   output logic [1:0]        dataSize,
   output logic              txPacketSizeChanged,
   output logic              hready,
   output logic              hresp
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ERR1  = 3'd4,
      ST_ERR2  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] BUF_LIM     = ADDR_W'(BUF_BYTES);
   localparam logic [ADDR_W-1:0] REG_LIM     = ADDR_W'(REG_BASE);
   localparam logic [ADDR_W-1:0] TXSIZE_ADDR = ADDR_W'(REG_BASE + TXSIZE_OFS);
   localparam logic [7:0]        WAIT_LIM    = 8'(WAIT_MAX);

   state_t              r_state;
   logic [7:0]          r_wait_cnt;
   logic [ADDR_W-1:0]   r_addr_p1;
   logic [1:0]          r_size_p1;
   logic                r_write_p1;

   state_t              w_state_nxt;
   logic                w_xfer;
   logic                w_buf_p1;
   logic                w_stall;
   logic                w_req;
   logic                w_accept;
   logic                w_req_err;
   logic [7:0]          w_wait_inc;

   function automatic logic f_req_err(input logic [ADDR_W-1:0] a,
                                      input logic [1:0]        sz,
                                      input logic              wr);
      logic e;
      e = 1'b0;
      if (sz == 2'b11)                           e = 1'b1;
      if ((sz == 2'b01) && a[0])                 e = 1'b1;
      if ((sz == 2'b10) && (a[1:0] != 2'b00))    e = 1'b1;
      if (a > TXSIZE_ADDR)                       e = 1'b1;
      if ((a >= BUF_LIM) && (a < REG_LIM))       e = 1'b1;
      // Only the TX packet size register is writable.
      if (wr && (a >= REG_LIM) && (a != TXSIZE_ADDR)) e = 1'b1;
      return e;
   endfunction

   assign state    = r_state;
   assign dataAddr = r_addr_p1;
   assign dataSize = r_size_p1;

   // ---- data phase: response and strobes ----
   always_comb begin
      w_xfer              = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_WAIT);
      w_buf_p1            = (r_addr_p1 < BUF_LIM);
      w_stall             = w_xfer && w_buf_p1 && bufBusy;
      hready              = 1'b1;
      hresp               = 1'b0;
      storeTxData         = 1'b0;
      getRxData           = 1'b0;
      regWrite            = 1'b0;
      regRead             = 1'b0;
      txPacketSizeChanged = 1'b0;
      if (r_state == ST_ERR1) begin
         hresp  = 1'b1;
         hready = 1'b0;
      end else if (r_state == ST_ERR2) begin
         hresp  = 1'b1;
      end else if (w_stall) begin
         hready = 1'b0;
      end else if (w_xfer) begin
         if (w_buf_p1) begin
            storeTxData = r_write_p1;
            getRxData   = !r_write_p1;
         end else begin
            regWrite            = r_write_p1;
            regRead             = !r_write_p1;
            txPacketSizeChanged = r_write_p1 && (r_addr_p1 == TXSIZE_ADDR);
         end
      end
   end

   // ---- address phase: acceptance and next state ----
   always_comb begin
      w_req       = hsel && ((htrans == 2'b10) || (htrans == 2'b11));
      w_accept    = w_req && hready && (r_state != ST_ERR2);
      w_req_err   = f_req_err(haddr, hsize, hwrite);
      w_wait_inc  = r_wait_cnt + 8'd1;
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_ERR1: w_state_nxt = ST_ERR2;
         ST_ERR2: w_state_nxt = ST_IDLE;
         default: begin
            if (w_stall) begin
               w_state_nxt = (w_wait_inc >= WAIT_LIM) ? ST_ERR1 : ST_WAIT;
            end else if (w_accept) begin
               if (w_req_err)   w_state_nxt = ST_ERR1;
               else if (hwrite) w_state_nxt = ST_WRITE;
               else             w_state_nxt = ST_READ;
            end
         end
      endcase
   end

   // ---- registered data phase ----
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
         r_addr_p1  <= '0;
         r_size_p1  <= '0;
         r_write_p1 <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= (w_state_nxt == ST_WAIT) ? w_wait_inc : 8'd0;
         if (w_accept) begin
            r_addr_p1  <= haddr;
            r_size_p1  <= hsize;
            r_write_p1 <= hwrite;
         end
      end
   end

endmodule
